// File: rtl/hamming_decoder.sv
`default_nettype none
// ============================================================================
// hamming_decoder: Hamming(7,4) single-error corrector with serial data output.
// Optional macro HAMMING_DEC_ERR_COUNT_EN adds a saturating corrected-word count.
// Revision: 1.0
// ============================================================================
module hamming_decoder (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] code_in,
  input  logic       code_valid,
  output logic       code_ready,
  input  logic       read,
  output logic       data_out,
  output logic       data_valid,
  output logic       err_detected,
  output logic [2:0] err_pos,
  output logic [7:0] err_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    SHIFT = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [6:0] r_word;
  logic [1:0] r_idx;
  logic       r_err_det;
  logic [2:0] r_err_pos;
  logic [2:0] w_syn;
  logic [6:0] w_flip;
  logic       w_bit;

  // Syndrome bit k covers every code position whose index has bit k set.
  assign w_syn[0] = r_word[0] ^ r_word[2] ^ r_word[4] ^ r_word[6];
  assign w_syn[1] = r_word[1] ^ r_word[2] ^ r_word[5] ^ r_word[6];
  assign w_syn[2] = r_word[3] ^ r_word[4] ^ r_word[5] ^ r_word[6];

  always_comb begin
    w_flip = '0;
    for (int k = 0; k < 7; k++) begin
      w_flip[k] = (w_syn == 3'(k + 1));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (code_valid) w_next = CHECK;
      CHECK:   w_next = SHIFT;
      SHIFT:   if (read && (r_idx == 2'd3)) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_word    <= '0;
      r_idx     <= '0;
      r_err_det <= 1'b0;
      r_err_pos <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (code_valid) begin
            r_word <= code_in;
            r_idx  <= '0;
          end
        end
        CHECK: begin
          r_word    <= r_word ^ w_flip;
          r_err_pos <= w_syn;
          r_err_det <= (w_syn != 3'd0);
        end
        SHIFT: begin
          // Wraps back to 0 on the d4 edge, ready for the next word.
          if (read) r_idx <= r_idx + 2'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    case (r_idx)
      2'd0:    w_bit = r_word[2];
      2'd1:    w_bit = r_word[4];
      2'd2:    w_bit = r_word[5];
      default: w_bit = r_word[6];
    endcase
  end

  assign code_ready   = (r_state == IDLE);
  assign data_valid   = (r_state == SHIFT);
  assign data_out     = (r_state == SHIFT) ? w_bit : 1'b0;
  assign err_detected = r_err_det;
  assign err_pos      = r_err_pos;

`ifdef HAMMING_DEC_ERR_COUNT_EN
  logic [7:0] r_err_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err_count <= '0;
    end else if ((r_state == CHECK) && (w_syn != 3'd0) && (r_err_count != 8'hFF)) begin
      r_err_count <= r_err_count + 8'd1;
    end
  end

  assign err_count = r_err_count;
`else
  assign err_count = 8'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hamming_decoder.sv
`default_nettype none
// ============================================================================
// tb_hamming_decoder: scoreboard bench for hamming_decoder.
// Revision: 1.0
// ============================================================================
module tb_hamming_decoder;

  logic       clk;
  logic       reset;
  logic [6:0] code_in;
  logic       code_valid;
  logic       code_ready;
  logic       read;
  logic       data_out;
  logic       data_valid;
  logic       err_detected;
  logic [2:0] err_pos;
  logic [7:0] err_count;

  int   n_vec = 0;
  int   n_err = 0;
  logic exp_q[$];
  int   cnt_model = 0;

  hamming_decoder dut (
    .clk          (clk),
    .reset        (reset),
    .code_in      (code_in),
    .code_valid   (code_valid),
    .code_ready   (code_ready),
    .read         (read),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .err_detected (err_detected),
    .err_pos      (err_pos),
    .err_count    (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Encoder model: d[0]=d1 .. d[3]=d4.
  function automatic logic [6:0] encode(input logic [3:0] d);
    logic [6:0] cw;
    cw[0] = d[0] ^ d[1] ^ d[3];
    cw[1] = d[0] ^ d[2] ^ d[3];
    cw[2] = d[0];
    cw[3] = d[1] ^ d[2] ^ d[3];
    cw[4] = d[1];
    cw[5] = d[2];
    cw[6] = d[3];
    return cw;
  endfunction

  function automatic logic [7:0] exp_count();
`ifdef HAMMING_DEC_ERR_COUNT_EN
    return 8'(cnt_model);
`else
    return 8'd0;
`endif
  endfunction

  // Scoreboard monitor: every consumed bit is checked against the queue.
  always @(negedge clk) begin
    logic eb;
    if (data_valid && read) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL data_unexpected: got bit %b, required no valid bit", data_out);
      end else begin
        eb = exp_q.pop_front();
        if (data_out !== eb) begin
          n_err++;
          $display("FAIL data_out: got %b, required %b", data_out, eb);
        end
      end
    end else if (!data_valid) begin
      n_vec++;
      if (data_out !== 1'b0) begin
        n_err++;
        $display("FAIL data_out_idle: got %b, required 0", data_out);
      end
    end
  end

  task automatic send(input logic [6:0] cw, input logic [3:0] d, input logic [2:0] syn);
    int t = 0;
    while (!code_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (!code_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL send_timeout: code_ready got %b, required 1", code_ready);
    end
    code_in    = cw;
    code_valid = 1'b1;
    for (int i = 0; i < 4; i++) exp_q.push_back(d[i]);
    if (syn != 3'd0 && cnt_model < 255) cnt_model++;
    @(posedge clk); #1;
    code_valid = 1'b0;
  endtask

  task automatic wait_done(input bit rnd_read);
    int t = 0;
    while (!(code_ready && exp_q.size() == 0) && t < 200) begin
      @(posedge clk); #1;
      if (rnd_read) read = 1'($urandom_range(0, 1));
      t++;
    end
    read = 1'b1;
    n_vec++;
    if (!(code_ready && exp_q.size() == 0)) begin
      n_err++;
      $display("FAIL done_timeout: code_ready %b queue %0d, required 1 and 0", code_ready, exp_q.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    code_valid = 1'b0;
    code_in = '0;
    read = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if ({code_ready, data_valid, data_out, err_detected, err_pos, err_count} !== {1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0}) begin
      n_err++;
      $display("FAIL reset_state: rdy %b dv %b do %b ed %b ep %0d ec %0d, required 1 0 0 0 0 0",
               code_ready, data_valid, data_out, err_detected, err_pos, err_count);
    end
    reset = 1'b0;
    cnt_model = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_clean();
    logic exp_dv;
    logic exp_rdy;
    read = 1'b1;
    send(7'b1001100, 4'b1001, 3'd0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      exp_dv  = (k >= 1 && k <= 4);
      exp_rdy = (k == 5);
      n_vec++;
      if (data_valid !== exp_dv || code_ready !== exp_rdy) begin
        n_err++;
        $display("FAIL clean_latency[%0d]: dv %b rdy %b, required %b %b", k, data_valid, code_ready, exp_dv, exp_rdy);
      end
      if (k == 1) begin
        n_vec++;
        if (err_detected !== 1'b0 || err_pos !== 3'd0 || err_count !== exp_count()) begin
          n_err++;
          $display("FAIL clean_err: ed %b ep %0d ec %0d, required 0 0 %0d", err_detected, err_pos, err_count, exp_count());
        end
      end
    end
    @(posedge clk); #1;
    wait_done(1'b0);
  endtask

  task automatic test_single_error();
    read = 1'b1;
    send(7'b1011100, 4'b1001, 3'd5);
    @(posedge clk); #1;
    @(negedge clk);
    n_vec++;
    if (err_detected !== 1'b1 || err_pos !== 3'd5 || err_count !== exp_count()) begin
      n_err++;
      $display("FAIL single_err: ed %b ep %0d ec %0d, required 1 5 %0d", err_detected, err_pos, err_count, exp_count());
    end
    wait_done(1'b0);
    n_vec++;
    if (err_detected !== 1'b1 || err_pos !== 3'd5) begin
      n_err++;
      $display("FAIL err_hold: ed %b ep %0d, required 1 5", err_detected, err_pos);
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] d;
    d = 4'b1011;
    read = 1'b1;
    send(encode(d), d, 3'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    read = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_vec++;
      if (data_valid !== 1'b1 || data_out !== d[1]) begin
        n_err++;
        $display("FAIL stall_hold[%0d]: dv %b do %b, required 1 %b", i, data_valid, data_out, d[1]);
      end
      @(posedge clk); #1;
    end
    read = 1'b1;
    wait_done(1'b0);
    send(7'b1001100, 4'b1001, 3'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    read = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    read = 1'b1;
    wait_done(1'b0);
  endtask

  task automatic test_busy();
    read = 1'b1;
    send(7'b1001100, 4'b1001, 3'd0);
    @(posedge clk); #1;
    code_in    = 7'b0110011;
    code_valid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    code_valid = 1'b0;
    wait_done(1'b0);
    repeat (2) begin @(posedge clk); #1; end
    n_vec++;
    if (code_ready !== 1'b1 || err_pos !== 3'd0 || err_detected !== 1'b0) begin
      n_err++;
      $display("FAIL busy_ignore: rdy %b ep %0d ed %b, required 1 0 0", code_ready, err_pos, err_detected);
    end
  endtask

  task automatic test_reset_mid_shift();
    read = 1'b1;
    send(7'b1011100, 4'b1001, 3'd5);
    @(posedge clk); #1;
    @(posedge clk); #2;
    reset = 1'b1;
    exp_q.delete();
    cnt_model = 0;
    #1;
    n_vec++;
    if ({code_ready, data_valid, data_out, err_detected, err_pos, err_count} !== {1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0}) begin
      n_err++;
      $display("FAIL async_reset: rdy %b dv %b do %b ed %b ep %0d ec %0d, required 1 0 0 0 0 0",
               code_ready, data_valid, data_out, err_detected, err_pos, err_count);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_vec++;
      if (data_valid !== 1'b0 || code_ready !== 1'b1 || err_pos !== 3'd0) begin
        n_err++;
        $display("FAIL post_reset[%0d]: dv %b rdy %b ep %0d, required 0 1 0", i, data_valid, code_ready, err_pos);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [3:0] d;
    logic [6:0] cw;
    int p;
    for (int n = 0; n < 20; n++) begin
      d  = 4'($urandom_range(0, 15));
      p  = $urandom_range(0, 7);
      cw = encode(d);
      if (p != 0) cw[p-1] = ~cw[p-1];
      send(cw, d, 3'(p));
      @(posedge clk); #1;
      n_vec++;
      if (err_pos !== 3'(p) || err_detected !== (p != 0)) begin
        n_err++;
        $display("FAIL rand_err[%0d]: ep %0d ed %b, required %0d %b", n, err_pos, err_detected, p, (p != 0));
      end
      wait_done(1'b1);
    end
  endtask

  task automatic test_saturation();
    logic [3:0] d;
    logic [6:0] cw;
    int p;
    reset = 1'b1;
    exp_q.delete();
    cnt_model = 0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    read = 1'b1;
    for (int n = 0; n < 256; n++) begin
      d  = 4'($urandom_range(0, 15));
      p  = $urandom_range(1, 7);
      cw = encode(d);
      cw[p-1] = ~cw[p-1];
      send(cw, d, 3'(p));
      wait_done(1'b0);
      n_vec++;
      if (err_count !== exp_count()) begin
        n_err++;
        $display("FAIL err_count[%0d]: got %0d, required %0d", n, err_count, exp_count());
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_single_error();
    test_backpressure();
    test_busy();
    test_reset_mid_shift();
    test_random();
    test_saturation();
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
